// File: rtl/wb_interconnect_n.sv
// Parametrised Wishbone address decoder / interconnect.
// Routes one master (SPI-to-Wishbone bridge) to NUM_SLAVES peripherals, each
// owning a 2**WIN_BITS address window. Slave select and master response are
// registered. A watchdog terminates transfers the selected slave never acks,
// unmapped addresses are terminated with wb_err_o, and a saturating counter
// records how many error terminations occurred.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   wb_adr_i/dat_i    master address / write data
//   wb_cyc_i/stb_i    master cycle / strobe
//   wb_we_i           master write enable
//   wb_dat_o          registered read data to master
//   wb_ack_o          one-cycle transfer-done pulse
//   wb_err_o          one-cycle transfer-failed pulse (unmapped or timeout)
//   s_adr_o/s_dat_o   per-slave address / write data (broadcast)
//   s_dat_i           per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_cyc_o/s_stb_o   registered one-hot slave cycle / strobe
//   s_we_o            per-slave write enable (broadcast)
//   s_ack_i           per-slave ack
//   err_count_o       saturating count of error terminations
module wb_interconnect_n #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WIN_BITS   = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            wb_adr_i,
  input  logic [DATA_W-1:0]            wb_dat_i,
  output logic [DATA_W-1:0]            wb_dat_o,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic [NUM_SLAVES*ADDR_W-1:0] s_adr_o,
  output logic [NUM_SLAVES*DATA_W-1:0] s_dat_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  output logic [NUM_SLAVES-1:0]        s_we_o,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  output logic [7:0]                   err_count_o
);

  localparam int unsigned IDX_W = ADDR_W - WIN_BITS;
  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [NUM_SLAVES-1:0]   slv_q, slv_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       dat_q, dat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0]        idx_c;
  logic                    mapped_c;
  logic [DATA_W-1:0]       s_rdata [NUM_SLAVES];

  // Window index of the current master address
  assign idx_c    = wb_adr_i[ADDR_W-1:WIN_BITS];
  assign mapped_c = (32'(idx_c) < NUM_SLAVES);

  // Unpack per-slave read data for indexing by the select register
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign s_rdata[g] = s_dat_i[g*DATA_W +: DATA_W];
  end

  // Broadcast address, data and write enable to every slave
  assign s_adr_o = {NUM_SLAVES{wb_adr_i}};
  assign s_dat_o = {NUM_SLAVES{wb_dat_i}};
  assign s_we_o  = {NUM_SLAVES{wb_we_i}};

  assign s_cyc_o     = slv_q;
  assign s_stb_o     = slv_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = dat_q;
  assign err_count_o = cnt_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      timer_q <= '0;
      slv_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      slv_q   <= slv_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    slv_d   = slv_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (mapped_c) begin
            sel_d   = SEL_W'(idx_c);
            slv_d   = NUM_SLAVES'(1) << idx_c;
            timer_d = '0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            dat_d   = '0;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = RESP;
          end
        end
      end

      BUSY: begin
        // Master abort beats everything: abandon silently
        if (!wb_cyc_i) begin
          slv_d   = '0;
          state_d = IDLE;
        end else if (s_ack_i[sel_q]) begin
          dat_d   = s_rdata[sel_q];
          slv_d   = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          slv_d   = '0;
          err_d   = 1'b1;
          dat_d   = '0;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      RESP: begin
        // ack/err pulse is being presented this cycle; return to IDLE
        state_d = IDLE;
      end

      default: begin
        slv_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Self-checking bench for wb_interconnect_n (NUM_SLAVES=4, 8-bit bus,
// 16-byte windows, TIMEOUT=64). A table of single transfers is run through
// one transfer task; abort, reset, saturation and back-to-back cases follow
// as hand-written sequences.
module tb_wb_interconnect_n;

  localparam int NS = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   wb_adr_i = '0;
  logic [DW-1:0]   wb_dat_i = '0;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_cyc_i = 1'b0;
  logic            wb_stb_i = 1'b0;
  logic            wb_we_i = 1'b0;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic [NS*AW-1:0] s_adr_o;
  logic [NS*DW-1:0] s_dat_o;
  logic [NS*DW-1:0] s_dat_i = '0;
  logic [NS-1:0]   s_cyc_o;
  logic [NS-1:0]   s_stb_o;
  logic [NS-1:0]   s_we_o;
  logic [NS-1:0]   s_ack_i = '0;
  logic [7:0]      err_count_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  wb_interconnect_n #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .WIN_BITS(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_ack_i(s_ack_i), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] adr;
    logic       we;
    logic [7:0] wdat;
    logic [7:0] rdat;     // data presented by the addressed slave
    int         dly;      // slave ack cycles after strobe appears
    logic       noise;    // unselected slaves ack continuously
    logic       exp_err;
    logic [3:0] exp_stb;
    int         exp_cyc;  // cycle of wb_ack_o/wb_err_o, request at cycle 0
    logic [7:0] exp_dat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int sl;
    int resp_cyc;
    int stb_cycles;
    logic [NS-1:0] noise_mask;
    sl = int'(v.adr[7:4]);
    resp_cyc = 0;
    stb_cycles = 0;
    noise_mask = '0;
    if (v.noise) begin
      noise_mask = '1;
      if (sl < NS) noise_mask[sl] = 1'b0;
    end
    tick();
    wb_adr_i = v.adr;
    wb_dat_i = v.wdat;
    wb_we_i  = v.we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < NS; i++)
      s_dat_i[i*DW +: DW] = (i == sl) ? v.rdat : 8'(8'hA0 + i);
    s_ack_i = noise_mask;
    for (int c = 1; c <= 100 && resp_cyc == 0; c++) begin
      tick();
      if (c == 1) begin
        check("stb_onehot", 32'(s_stb_o), 32'(v.exp_stb));
        check("cyc_onehot", 32'(s_cyc_o), 32'(v.exp_stb));
        check("we_bcast", 32'(s_we_o), 32'({NS{v.we}}));
        check("adr_bcast", s_adr_o, {NS{v.adr}});
        check("dat_bcast", s_dat_o, {NS{v.wdat}});
      end
      if (s_stb_o != '0) stb_cycles++;
      if (wb_ack_o || wb_err_o) begin
        resp_cyc = c;
        if (v.exp_err) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        check("resp_cycle", 32'(resp_cyc), 32'(v.exp_cyc));
        check("ack", 32'(wb_ack_o), 32'(!v.exp_err));
        check("err", 32'(wb_err_o), 32'(v.exp_err));
        check("rdata", 32'(wb_dat_o), 32'(v.exp_dat));
        check("err_count", 32'(err_count_o), 32'(exp_cnt));
        check("stb_dropped", 32'(s_stb_o), 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        s_ack_i  = '0;
      end else begin
        s_ack_i = noise_mask;
        if (c == 1 + v.dly && sl < NS) s_ack_i[sl] = 1'b1;
      end
    end
    if (resp_cyc == 0) begin
      check("response_seen", 32'h0, 32'h1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      s_ack_i  = '0;
    end
    check("stb_cycles", 32'(stb_cycles), (v.exp_stb == '0) ? 32'h0 : 32'(v.exp_cyc - 1));
    tick();
    check("pulse_end", 32'({wb_ack_o, wb_err_o}), 32'h0);
    check("dat_hold", 32'(wb_dat_o), 32'(v.exp_dat));
  endtask

  initial begin
    int seen;
    int errs_seen;
    int ack2_cyc;
    int ack5_cyc;
    //           adr    we   wdat   rdat   dly   noise exp_err stb      cyc dat
    vecs[0] = '{8'h13, 1'b1, 8'h5A, 8'h77, 2,    1'b0, 1'b0, 4'b0010, 4,  8'h77};
    vecs[1] = '{8'h21, 1'b0, 8'h00, 8'hC3, 0,    1'b0, 1'b0, 4'b0100, 2,  8'hC3};
    vecs[2] = '{8'h47, 1'b0, 8'h00, 8'h55, 0,    1'b0, 1'b1, 4'b0000, 1,  8'h00};
    vecs[3] = '{8'h3F, 1'b0, 8'h00, 8'h9E, 1,    1'b1, 1'b0, 4'b1000, 3,  8'h9E};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 8'h01, 5,    1'b1, 1'b0, 4'b0001, 7,  8'h01};
    vecs[5] = '{8'hF0, 1'b1, 8'hEE, 8'h12, 0,    1'b0, 1'b1, 4'b0000, 1,  8'h00};
    vecs[6] = '{8'h10, 1'b0, 8'h00, 8'hFF, 0,    1'b0, 1'b0, 4'b0010, 2,  8'hFF};
    vecs[7] = '{8'h05, 1'b0, 8'h00, 8'h44, 1000, 1'b0, 1'b1, 4'b0001, 65, 8'h00};
    vecs[8] = '{8'h0A, 1'b0, 8'h00, 8'h6B, 63,   1'b0, 1'b0, 4'b0001, 65, 8'h6B};

    // Reset state
    tick(); tick();
    check("rst_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_stb", 32'(s_stb_o), 32'h0);
    check("rst_ack_err", 32'({wb_ack_o, wb_err_o}), 32'h0);
    check("rst_dat", 32'(wb_dat_o), 32'h0);
    check("rst_cnt", 32'(err_count_o), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Master abort at cycle 3 of a BUSY transfer
    tick();
    wb_adr_i = 8'h22; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; s_ack_i = '0;
    tick();
    check("abort_c1_cyc", 32'(s_cyc_o), 32'h4);
    tick();
    tick();
    check("abort_c3_cyc", 32'(s_cyc_o), 32'h4);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    check("abort_c4_cyc", 32'(s_cyc_o), 32'h0);
    check("abort_c4_stb", 32'(s_stb_o), 32'h0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_ack_o || wb_err_o) seen++;
      tick();
    end
    check("abort_no_resp", 32'(seen), 32'h0);
    check("abort_cnt", 32'(err_count_o), 32'(exp_cnt));
    check("abort_dat_hold", 32'(wb_dat_o), 32'h6B);

    // Reset asserted mid-BUSY
    wb_adr_i = 8'h31; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    tick();
    check("rstb_c1_stb", 32'(s_stb_o), 32'h8);
    tick();
    rst = 1'b0;
    tick();
    check("rstb_cyc", 32'(s_cyc_o), 32'h0);
    check("rstb_stb", 32'(s_stb_o), 32'h0);
    check("rstb_ack_err", 32'({wb_ack_o, wb_err_o}), 32'h0);
    check("rstb_dat", 32'(wb_dat_o), 32'h0);
    check("rstb_cnt", 32'(err_count_o), 32'h0);
    exp_cnt = 0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wb_ack_o || wb_err_o || s_stb_o != '0) seen++;
    end
    check("rstb_quiet", 32'(seen), 32'h0);

    // 300 unmapped accesses saturate the error counter
    errs_seen = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      wb_adr_i = 8'h80; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      tick();
      if (wb_err_o) errs_seen++;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    end
    check("sat_err_pulses", 32'(errs_seen), 32'd300);
    check("sat_count", 32'(err_count_o), 32'd255);
    tick();

    // Back-to-back reads of 0x00 and 0x10, both slaves ack immediately
    s_dat_i = '0;
    s_dat_i[0*DW +: DW] = 8'h3C;
    s_dat_i[1*DW +: DW] = 8'hD2;
    ack2_cyc = 0;
    ack5_cyc = 0;
    wb_adr_i = 8'h00; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      s_ack_i = s_stb_o;
      if (wb_ack_o && c == 2 && wb_dat_o == 8'h3C) ack2_cyc = c;
      if (wb_ack_o && c == 5 && wb_dat_o == 8'hD2) ack5_cyc = c;
      if (c == 2) begin
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
      end
      if (c == 3) begin
        wb_adr_i = 8'h10; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      end
      if (c == 4) check("b2b_stb2", 32'(s_stb_o), 32'h2);
      if (c == 5) begin
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
      end
    end
    s_ack_i = '0;
    check("b2b_first_ack", 32'(ack2_cyc), 32'd2);
    check("b2b_second_ack", 32'(ack5_cyc), 32'd5);
    check("b2b_err_cnt", 32'(err_count_o), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_n.md
Name: wb_interconnect_n

Overview:
- Parametrised successor to the fixed three-slave Wishbone address decoder.
- Sits between the SPI-to-Wishbone bridge and NUM_SLAVES peripherals (RGB LED, HDMI, USB serial, and future blocks).
- Decodes fixed-size address windows and registers slave select and response.
- Adds a bus-timeout watchdog and unmapped-address error termination (wb_err_o), plus a saturating error counter for debug.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WIN_BITS, 4, log2 of window size; slave i owns addresses whose bits [ADDR_W-1:WIN_BITS] equal i.
- TIMEOUT, 64, cycles a slave strobe may stay asserted without ack (2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- wb_adr_i  in  ADDR_W  master address
- wb_dat_i  in  DATA_W  master write data
- wb_dat_o  out  DATA_W  read data to master (registered)
- wb_cyc_i  in  1  master cycle
- wb_stb_i  in  1  master strobe
- wb_we_i  in  1  master write enable
- wb_ack_o  out  1  transfer done, one-cycle pulse
- wb_err_o  out  1  transfer failed (unmapped or timeout), one-cycle pulse
- s_adr_o  out  NUM_SLAVES*ADDR_W  per-slave address, broadcast from wb_adr_i
- s_dat_o  out  NUM_SLAVES*DATA_W  per-slave write data, broadcast from wb_dat_i
- s_dat_i  in  NUM_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
- s_cyc_o  out  NUM_SLAVES  one-hot slave cycle (registered)
- s_stb_o  out  NUM_SLAVES  one-hot slave strobe (registered)
- s_we_o  out  NUM_SLAVES  per-slave write enable, broadcast from wb_we_i
- s_ack_i  in  NUM_SLAVES  per-slave ack
- err_count_o  out  8  saturating count of error terminations

Behaviour:
- Reset (rst==0 at a clk edge):
  - FSM goes to IDLE.
  - s_cyc_o, s_stb_o, wb_ack_o, wb_err_o, wb_dat_o and err_count_o are all 0.
  - Timeout counter and select register are cleared.
  - Reset mid-transfer abandons the transfer silently; no ack or err is issued.
- Index: idx = wb_adr_i[ADDR_W-1:WIN_BITS]. Mapped when idx < NUM_SLAVES.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - wb_cyc_i&wb_stb_i with mapped idx: latch sel=idx, set s_cyc_o[sel]=s_stb_o[sel]=1, clear timer, go to BUSY.
  - wb_cyc_i&wb_stb_i with unmapped idx: go to RESP with err flag set; no slave strobed.
- BUSY:
  - s_ack_i[sel]==1: capture s_dat_i[sel] into wb_dat_o, drop s_cyc_o/s_stb_o, go to RESP with ack flag.
  - No ack and timer==TIMEOUT-1: drop slave strobe, go to RESP with err flag.
  - Otherwise timer increments.
  - Ack and timeout threshold in the same cycle: ack wins.
  - wb_cyc_i falls (master abort): drop slave signals, go to IDLE; no ack or err.
  - s_ack_i bits of unselected slaves are ignored.
- RESP:
  - wb_ack_o or wb_err_o is high for exactly one cycle, never both; then go to IDLE.
  - On error, wb_dat_o is 0 and err_count_o increments, saturating at 255.
- Latency: request seen in IDLE at cycle 0; slave strobe at cycle 1.
  - Slave ack at cycle k gives master ack at k+1.
  - Minimum, for a combinational-ack slave: wb_ack_o at cycle 2.
  - Unmapped address: wb_err_o at cycle 1.
- Back-to-back: the master may reassert stb the cycle after ack; IDLE accepts it immediately.
- wb_dat_o holds its last captured value outside RESP.
- Slave strobe is asserted for exactly TIMEOUT cycles on timeout.

Test Plan:
- Write 0x5A to 0x13 (NUM_SLAVES=4), slave 1 acks 2 cycles after strobe -> s_stb_o=0b0010 from cycle 1; wb_ack_o one cycle at cycle 4; no other slave strobed.
- Read 0x21, slave 2 returns 0xC3 with immediate ack -> wb_dat_o=0xC3 and wb_ack_o=1 at cycle 2; wb_err_o=0.
- Read 0x47 (idx 4, unmapped) -> wb_err_o at cycle 1; s_stb_o stays 0; wb_dat_o=0; err_count_o=1.
- Slave 0 never acks, TIMEOUT=64 -> s_stb_o[0] high exactly 64 cycles; then wb_err_o pulse; err_count_o increments. Ack on the 64th cycle -> wb_ack_o instead, no err.
- Master drops wb_cyc_i at cycle 3 of a BUSY transfer -> s_cyc_o=0 next cycle; no ack or err. rst=0 mid-BUSY -> all outputs 0 next edge.
- 300 unmapped accesses -> err_count_o saturates at 255. Back-to-back reads of 0x00 and 0x10 -> two acks, each with correct data.
